biu_rd_arbiter: RTL and testbench
=================================

Name: biu_rd_arbiter

Overview:
- Shares one AXI-lite read path to system memory between the instruction BIU (port I) and the data BIU (port D) of kiwi_subsys.
- Arbitrates AR requests round-robin and keeps one read outstanding at a time.
- Routes each R beat back to the requester that owns the outstanding read.
- The D-side write channels do not pass through this block.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
PRIO_D, 1, requester that wins the first arbitration after reset (1 = D, 0 = I)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_araddr  in  ADDR_W  I-port read address
i_arvalid  in  1  I-port AR valid
i_arready  out  1  I-port AR ready
i_rdata  out  DATA_W  I-port read data
i_rresp  out  2  I-port read response
i_rvalid  out  1  I-port R valid
i_rready  in  1  I-port R ready
d_araddr  in  ADDR_W  D-port read address
d_arvalid  in  1  D-port AR valid
d_arready  out  1  D-port AR ready
d_rdata  out  DATA_W  D-port read data
d_rresp  out  2  D-port read response
d_rvalid  out  1  D-port R valid
d_rready  in  1  D-port R ready
m_araddr  out  ADDR_W  memory AR address (registered)
m_arvalid  out  1  memory AR valid
m_arready  in  1  memory AR ready
m_rdata  in  DATA_W  memory read data
m_rresp  in  2  memory read response
m_rvalid  in  1  memory R valid
m_rready  out  1  memory R ready
busy  out  1  high from grant until the R beat is accepted

Behaviour:
- FSM states: IDLE, AR, R.
- Reset (rst=1 at a clk edge):
  - state=IDLE; m_arvalid=0; m_araddr=0.
  - last_grant = ~PRIO_D, so the PRIO_D requester wins the first tie.
  - All ready and valid outputs are 0; busy=0.
  - Reset mid-transaction abandons the read; any late m_rvalid after reset is accepted with m_rready=0 only once a new owner exists, so the memory model must also be reset.
- IDLE:
  - Combinational grant: if exactly one arvalid is high, that requester wins. If both are high, the requester other than last_grant wins.
  - The winner's *_arready=1 in the same cycle; the loser's is 0. Handshake completes that cycle.
  - On handshake: latch address into m_araddr, set owner=winner, last_grant=winner, go to AR. m_arvalid=1 from the next cycle.
- AR:
  - Hold m_arvalid=1 with m_araddr stable until m_arready.
  - On m_arvalid & m_arready: drop m_arvalid, go to R.
  - Both *_arready=0.
- R:
  - Pass-through routing to the owner: owner_rvalid=m_rvalid, owner_rdata=m_rdata, owner_rresp=m_rresp, m_rready=owner_rready.
  - The non-owner sees rvalid=0 and rdata/rresp=0.
  - On m_rvalid & m_rready: go to IDLE.
  - m_rready=0 in IDLE and AR; any m_rvalid in those states is a protocol error and is not forwarded.
- Latency: AR at the I/D port in cycle t gives m_arvalid in cycle t+1 at the earliest. The R beat reaches the owner in the same cycle it appears at the memory. Minimum issue interval is 3 cycles.
- Fairness: with both requesters continuously valid, grants strictly alternate. Neither port waits more than one transaction.
- A requester dropping arvalid before being granted is legal (AXI-lite violation tolerated); nothing is latched.
- Responses are forwarded unmodified (OKAY/SLVERR/DECERR).
- Width: addresses and data are copied bit-exact. No arithmetic.

Decomposition:
- Shared package kiwi_biu_pkg:
  - typedef req_id_e {REQ_I=0, REQ_D=1}
  - typedef arb_state_e {IDLE, AR, R}
  - AXI resp constants RESP_OKAY, RESP_SLVERR, RESP_DECERR
- One natural sub-module: rr_arb2 (2-input round-robin grant from req[1:0], last_grant, PRIO_D). It is reusable for a future write arbiter.

Test Plan:
- Single I read: i_araddr=0x1000, memory returns 0xDEADBEEF_00000013 OKAY after 2 cycles -> i_rvalid with that data, d_rvalid never 1, busy high for 4 cycles.
- Simultaneous first request after reset (PRIO_D=1): I=0x2000, D=0x8000 -> D granted first. m_araddr sequence is 0x8000 then 0x2000; data returned to the correct ports.
- Back-pressure: m_arready low for 5 cycles, then d_rready low for 3 cycles with m_rvalid high -> m_araddr stable and m_arvalid held; the R beat is held and accepted only when d_rready=1. No new grant occurs during this window.
- Starvation: both ports valid for 10 transactions -> grants alternate D,I,D,I…, 5 each.
- Error response: m_rresp=2'b10 for I read -> i_rresp=2'b10, FSM returns to IDLE.
- Reset in R state: assert rst for 1 cycle while awaiting R -> next cycle state=IDLE, m_arvalid=0, busy=0, next arbitration favours PRIO_D.

Source files
------------

// File: rtl/kiwi_biu_pkg.sv
// Shared types and constants for the kiwi_subsys bus interface units.
package kiwi_biu_pkg;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } arb_state_e;

  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; remembers the last winner and on a tie
// grants the other requester. PRIO_D picks who wins the first tie after reset.
module rr_arb2
  import kiwi_biu_pkg::*;
#(
  parameter bit PRIO_D = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       grant_valid_c,
  output req_id_e    grant_c
);

  req_id_e last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PRIO_D ? REQ_I : REQ_D;
    end else if (take && grant_valid_c) begin
      last_grant <= grant_c;
    end
  end

  always_comb begin
    grant_valid_c = |req;
    grant_c       = REQ_I;
    if (req == 2'b11) begin
      grant_c = (last_grant == REQ_D) ? REQ_I : REQ_D;
    end else if (req[1]) begin
      grant_c = REQ_D;
    end
  end

endmodule

// File: rtl/biu_rd_arbiter.sv
// Shares one AXI-lite read path between the I and D BIUs: round-robin AR
// arbitration, a single outstanding read, R beat routed back to its owner.
module biu_rd_arbiter
  import kiwi_biu_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter bit          PRIO_D = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic              i_arvalid,
  output logic              i_arready,
  output logic [DATA_W-1:0] i_rdata,
  output logic [RESP_W-1:0] i_rresp,
  output logic              i_rvalid,
  input  logic              i_rready,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic              d_arvalid,
  output logic              d_arready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [RESP_W-1:0] d_rresp,
  output logic              d_rvalid,
  input  logic              d_rready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [RESP_W-1:0] m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              busy
);

  arb_state_e state;
  req_id_e    owner;
  logic       grant_valid_c;
  req_id_e    grant_c;
  logic       take_c;

  // A grant is only taken while idle and out of reset; it is the AR handshake.
  assign take_c = !rst && (state == IDLE) && grant_valid_c;

  rr_arb2 #(
    .PRIO_D(PRIO_D)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          ({d_arvalid, i_arvalid}),
    .take         (take_c),
    .grant_valid_c(grant_valid_c),
    .grant_c      (grant_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= REQ_I;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_c) begin
            m_araddr  <= (grant_c == REQ_D) ? d_araddr : i_araddr;
            owner     <= grant_c;
            m_arvalid <= 1'b1;
            busy      <= 1'b1;
            state     <= AR;
          end
        end
        AR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            state     <= R;
          end
        end
        R: begin
          if (m_rvalid && m_rready) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // AR ready to the winner and R pass-through to the owner; silent otherwise.
  always_comb begin
    i_arready = 1'b0;
    d_arready = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    i_rresp   = '0;
    d_rresp   = '0;
    m_rready  = 1'b0;
    if (take_c) begin
      if (grant_c == REQ_D) d_arready = 1'b1;
      else                  i_arready = 1'b1;
    end
    if (!rst && (state == R)) begin
      if (owner == REQ_D) begin
        d_rvalid = m_rvalid;
        d_rdata  = m_rdata;
        d_rresp  = m_rresp;
        m_rready = d_rready;
      end else begin
        i_rvalid = m_rvalid;
        i_rdata  = m_rdata;
        i_rresp  = m_rresp;
        m_rready = i_rready;
      end
    end
  end

endmodule

// File: tb/tb_biu_rd_arbiter.sv
// Self-checking bench for biu_rd_arbiter: arbitration table, directed
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_biu_rd_arbiter;
  import kiwi_biu_pkg::*;

  logic        clk, rst;
  logic [63:0] i_araddr, d_araddr, m_araddr;
  logic        i_arvalid, i_arready, d_arvalid, d_arready;
  logic [63:0] i_rdata, d_rdata, m_rdata;
  logic [1:0]  i_rresp, d_rresp, m_rresp;
  logic        i_rvalid, i_rready, d_rvalid, d_rready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, busy;

  int vectors = 0;
  int miscompares = 0;

  biu_rd_arbiter #(.ADDR_W(64), .DATA_W(64), .PRIO_D(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv, dv;
    logic [63:0] ia, da, data;
    logic [1:0]  resp;
    logic        exp_i, exp_d;
  } vec_t;

  typedef struct {
    logic        who;
    logic [63:0] addr;
    logic        ar_done;
  } txn_t;

  vec_t        vt [9];
  txn_t        q [$];
  int          busy_cnt, ng, gi, gd;
  logic        d_seen, nxt, free, rph, own, win, m_last, e_i_ar, e_d_ar;
  logic [63:0] m_addr, exp_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_araddr = '0; d_araddr = '0; i_arvalid = 1'b0; d_arvalid = 1'b0;
    i_rready = 1'b0; d_rready = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
    m_rdata = '0; m_rresp = RESP_OKAY;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    // {iv, dv, ia, da, data, resp, exp_i_arready, exp_d_arready}; first tie after reset goes to D
    vt[0] = '{1, 1, 64'h2000, 64'h8000, 64'h1111_0000_0000_8000, RESP_OKAY,   0, 1};
    vt[1] = '{1, 1, 64'h2000, 64'h8004, 64'h2222_0000_0000_2000, RESP_OKAY,   1, 0};
    vt[2] = '{1, 0, 64'h1000, 64'h9000, 64'h3333_3333_3333_3333, RESP_OKAY,   1, 0};
    vt[3] = '{1, 1, 64'h1008, 64'h9008, 64'h4444_4444_4444_4444, RESP_OKAY,   0, 1};
    vt[4] = '{0, 0, 64'h1010, 64'h9010, 64'h5555_5555_5555_5555, RESP_OKAY,   0, 0};
    vt[5] = '{0, 1, 64'h1018, 64'h9018, 64'h6666_6666_6666_6666, RESP_OKAY,   0, 1};
    vt[6] = '{1, 1, 64'h1020, 64'h9020, 64'h7777_7777_7777_7777, RESP_SLVERR, 1, 0};
    vt[7] = '{1, 0, 64'h1028, 64'h9028, 64'h8888_8888_8888_8888, RESP_DECERR, 1, 0};
    vt[8] = '{1, 1, 64'h1030, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, RESP_OKAY, 0, 1};

    // Reset state and single I read: busy from grant to R accept.
    do_reset();
    mid();
    check("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    check("rst_m_araddr", m_araddr, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_m_rready", 64'(m_rready), 64'd0);
    check("rst_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
    check("rst_arready", 64'({i_arready, d_arready}), 64'd0);
    tick();
    i_arvalid = 1'b1; i_araddr = 64'h1000; i_rready = 1'b1;
    busy_cnt = 0; d_seen = 1'b0;
    for (int c = 0; c < 7; c++) begin
      m_arready = (c == 1);
      m_rvalid  = (c == 4);
      m_rdata   = 64'hDEAD_BEEF_0000_0013;
      m_rresp   = RESP_OKAY;
      if (c > 0) i_arvalid = 1'b0;
      mid();
      busy_cnt += int'(busy);
      d_seen |= d_rvalid;
      if (c == 1) check("single_m_araddr", m_araddr, 64'h1000);
      if (c == 4) begin
        check("single_i_rvalid", 64'(i_rvalid), 64'd1);
        check("single_i_rdata", i_rdata, 64'hDEAD_BEEF_0000_0013);
        check("single_i_rresp", 64'(i_rresp), 64'(RESP_OKAY));
      end
      tick();
    end
    check("single_busy_cycles", 64'(busy_cnt), 64'd4);
    check("single_d_rvalid_seen", 64'(d_seen), 64'd0);

    // Arbitration table, each granted entry carried through a full read.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      i_arvalid = vt[k].iv; d_arvalid = vt[k].dv;
      i_araddr = vt[k].ia;  d_araddr = vt[k].da;
      mid();
      check("tbl_i_arready", 64'(i_arready), 64'(vt[k].exp_i));
      check("tbl_d_arready", 64'(d_arready), 64'(vt[k].exp_d));
      exp_addr = vt[k].exp_d ? vt[k].da : vt[k].ia;
      tick();
      i_arvalid = 1'b0; d_arvalid = 1'b0;
      if (vt[k].exp_i || vt[k].exp_d) begin
        mid();
        check("tbl_m_arvalid", 64'(m_arvalid), 64'd1);
        check("tbl_m_araddr", m_araddr, exp_addr);
        check("tbl_busy", 64'(busy), 64'd1);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = vt[k].data; m_rresp = vt[k].resp;
        i_rready = 1'b1; d_rready = 1'b1;
        mid();
        check("tbl_i_rvalid", 64'(i_rvalid), 64'(vt[k].exp_i));
        check("tbl_d_rvalid", 64'(d_rvalid), 64'(vt[k].exp_d));
        check("tbl_i_rdata", i_rdata, vt[k].exp_i ? vt[k].data : 64'd0);
        check("tbl_d_rdata", d_rdata, vt[k].exp_d ? vt[k].data : 64'd0);
        check("tbl_i_rresp", 64'(i_rresp), vt[k].exp_i ? 64'(vt[k].resp) : 64'd0);
        check("tbl_d_rresp", 64'(d_rresp), vt[k].exp_d ? 64'(vt[k].resp) : 64'd0);
        check("tbl_m_rready", 64'(m_rready), 64'd1);
        tick();
        m_rvalid = 1'b0; i_rready = 1'b0; d_rready = 1'b0;
        mid();
        check("tbl_busy_done", 64'(busy), 64'd0);
        tick();
      end else begin
        mid();
        check("tbl_none_m_arvalid", 64'(m_arvalid), 64'd0);
        check("tbl_none_busy", 64'(busy), 64'd0);
        tick();
      end
    end

    // Back-pressure on AR then on R; a waiting I request must not be granted.
    do_reset();
    d_arvalid = 1'b1; d_araddr = 64'hC0DE_0040;
    mid();
    check("bp_d_arready", 64'(d_arready), 64'd1);
    tick();
    d_arvalid = 1'b0; i_arvalid = 1'b1; i_araddr = 64'h3000;
    for (int c = 0; c < 5; c++) begin
      mid();
      check("bp_m_arvalid_held", 64'(m_arvalid), 64'd1);
      check("bp_m_araddr_stable", m_araddr, 64'hC0DE_0040);
      check("bp_ar_no_grant", 64'(i_arready), 64'd0);
      tick();
    end
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 64'h0123_4567_89AB_CDEF; d_rready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mid();
      check("bp_d_rvalid", 64'(d_rvalid), 64'd1);
      check("bp_m_rready_low", 64'(m_rready), 64'd0);
      check("bp_r_busy", 64'(busy), 64'd1);
      check("bp_r_no_grant", 64'(i_arready), 64'd0);
      tick();
    end
    d_rready = 1'b1;
    mid();
    check("bp_m_rready", 64'(m_rready), 64'd1);
    check("bp_d_rdata", d_rdata, 64'h0123_4567_89AB_CDEF);
    i_arvalid = 1'b0;
    tick();
    m_rvalid = 1'b0; d_rready = 1'b0;
    mid();
    check("bp_busy_done", 64'(busy), 64'd0);

    // Both requesters always valid: grants alternate D,I,D,I...
    do_reset();
    i_arvalid = 1'b1; d_arvalid = 1'b1; i_rready = 1'b1; d_rready = 1'b1; m_arready = 1'b1;
    ng = 0; gi = 0; gd = 0;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      mid();
      if (i_arready || d_arready) begin
        check("starve_alternate", 64'(d_arready), 64'(ng % 2 == 0));
        ng++;
        gi += int'(i_arready);
        gd += int'(d_arready);
      end
      nxt = m_rvalid && !m_rready;
      if (m_arvalid && m_arready) nxt = 1'b1;
      tick();
      m_rvalid = nxt;
    end
    check("starve_grants", 64'(ng), 64'd10);
    check("starve_i_count", 64'(gi), 64'd5);
    check("starve_d_count", 64'(gd), 64'd5);

    // Reset while the read awaits R: abandoned, and the next tie favours D again.
    do_reset();
    d_arvalid = 1'b1; d_araddr = 64'h5000;
    tick();
    d_arvalid = 1'b0; m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    mid();
    check("rstr_busy_before", 64'(busy), 64'd1);
    rst = 1'b1; m_rvalid = 1'b1; d_rready = 1'b1;
    tick();
    rst = 1'b0; i_arvalid = 1'b1; d_arvalid = 1'b1;
    mid();
    check("rstr_m_arvalid", 64'(m_arvalid), 64'd0);
    check("rstr_busy", 64'(busy), 64'd0);
    check("rstr_d_rvalid", 64'(d_rvalid), 64'd0);
    check("rstr_m_rready", 64'(m_rready), 64'd0);
    check("rstr_d_first", 64'(d_arready), 64'd1);
    check("rstr_i_loses", 64'(i_arready), 64'd0);
    tick();

    // Randomized traffic against a transaction-level model.
    do_reset();
    q.delete();
    m_last = 1'b0;
    m_addr = '0;
    for (int c = 0; c < 500; c++) begin
      i_arvalid = 1'($urandom_range(0, 1));
      d_arvalid = 1'($urandom_range(0, 1));
      i_araddr  = {$urandom(), $urandom()};
      d_araddr  = {$urandom(), $urandom()};
      m_arready = ($urandom_range(0, 3) != 0);
      m_rvalid  = 1'($urandom_range(0, 1));
      m_rdata   = {$urandom(), $urandom()};
      m_rresp   = 2'($urandom_range(0, 3));
      i_rready  = 1'($urandom_range(0, 1));
      d_rready  = 1'($urandom_range(0, 1));
      mid();
      free = (q.size() == 0);
      e_i_ar = 1'b0; e_d_ar = 1'b0; win = 1'b0;
      if (free && (i_arvalid || d_arvalid)) begin
        win = (i_arvalid && d_arvalid) ? !m_last : d_arvalid;
        e_d_ar = win;
        e_i_ar = !win;
      end
      rph = !free && q[0].ar_done;
      own = free ? 1'b0 : q[0].who;
      check("rnd_i_arready", 64'(i_arready), 64'(e_i_ar));
      check("rnd_d_arready", 64'(d_arready), 64'(e_d_ar));
      check("rnd_m_arvalid", 64'(m_arvalid), 64'(!free && !q[0].ar_done));
      check("rnd_m_araddr", m_araddr, m_addr);
      check("rnd_busy", 64'(busy), 64'(!free));
      check("rnd_i_rvalid", 64'(i_rvalid), 64'(rph && !own && m_rvalid));
      check("rnd_d_rvalid", 64'(d_rvalid), 64'(rph && own && m_rvalid));
      check("rnd_i_rdata", i_rdata, (rph && !own) ? m_rdata : 64'd0);
      check("rnd_d_rdata", d_rdata, (rph && own) ? m_rdata : 64'd0);
      check("rnd_i_rresp", 64'(i_rresp), (rph && !own) ? 64'(m_rresp) : 64'd0);
      check("rnd_d_rresp", 64'(d_rresp), (rph && own) ? 64'(m_rresp) : 64'd0);
      check("rnd_m_rready", 64'(m_rready), 64'(rph && (own ? d_rready : i_rready)));
      if (e_i_ar || e_d_ar) begin
        m_addr = win ? d_araddr : i_araddr;
        q.push_back('{win, m_addr, 1'b0});
        m_last = win;
      end else if (!free && !q[0].ar_done && m_arready) begin
        q[0].ar_done = 1'b1;
      end else if (rph && m_rvalid && (own ? d_rready : i_rready)) begin
        void'(q.pop_front());
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
